// File: rtl/spi_master_ctrl_if.sv
// Host/pin bundle for spi_master_ctrl: request/response handshake plus the four SPI pins.
// master = controller side, slave = host/pin side.
interface spi_master_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  START;
    logic [DATA_WIDTH-1:0] TX_DATA;
    logic [DATA_WIDTH-1:0] RX_DATA;
    logic                  BUSY;
    logic                  DONE;
    logic                  SCLK;
    logic                  MOSI;
    logic                  MISO;
    logic                  CS_N;

    modport master (
        input  START, TX_DATA, MISO,
        output RX_DATA, BUSY, DONE, SCLK, MOSI, CS_N
    );

    modport slave (
        output START, TX_DATA, MISO,
        input  RX_DATA, BUSY, DONE, SCLK, MOSI, CS_N
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one full-duplex DATA_WIDTH-bit transfer per accepted START.
// Define SPI_LSB_FIRST_EN to shift LSB first; default build shifts MSB first.
//
// state | meaning
// IDLE  | CS_N high, waiting for START
// LEAD  | CS_N low, setup time before first SCLK rise
// HIGH  | SCLK high, MISO sampled on entry
// LOW   | SCLK low, next MOSI bit presented on entry
// TRAIL | CS_N hold after last SCLK fall
module spi_master_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic             CLK,
    input  logic             CLR,
    spi_master_ctrl_if.master bus
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEAD  = 3'd1;
    localparam logic [2:0] ST_HIGH  = 3'd2;
    localparam logic [2:0] ST_LOW   = 3'd3;
    localparam logic [2:0] ST_TRAIL = 3'd4;

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  cs_n_q, cs_n_d;

    logic                  phase_end;
    logic                  first_bit;
    logic                  next_bit;
    logic [DATA_WIDTH-1:0] sh_sampled;

    // One shift register carries both directions: TX bits leave one end as
    // MISO bits enter the other, so after the last rise it holds the RX word.
`ifdef SPI_LSB_FIRST_EN
    assign first_bit  = bus.TX_DATA[0];
    assign next_bit   = sh_q[0];
    assign sh_sampled = {bus.MISO, sh_q[DATA_WIDTH-1:1]};
`else
    assign first_bit  = bus.TX_DATA[DATA_WIDTH-1];
    assign next_bit   = sh_q[DATA_WIDTH-1];
    assign sh_sampled = {sh_q[DATA_WIDTH-2:0], bus.MISO};
`endif

    assign phase_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        rx_d    = rx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;

        if (state_q != ST_IDLE) begin
            cnt_d = phase_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    sh_d    = bus.TX_DATA;
                    mosi_d  = first_bit;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = ST_LEAD;
                end
            end
            ST_LEAD, ST_LOW: begin
                if (phase_end) begin
                    sclk_d  = 1'b1;
                    sh_d    = sh_sampled;
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (phase_end) begin
                    sclk_d = 1'b0;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_TRAIL;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        mosi_d  = next_bit;
                        state_d = ST_LOW;
                    end
                end
            end
            ST_TRAIL: begin
                if (phase_end) begin
                    cs_n_d  = 1'b1;
                    rx_d    = sh_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    mosi_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
                busy_d  = 1'b0;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                cs_n_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            rx_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
        end
    end

    assign bus.RX_DATA = rx_q;
    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;
    assign bus.SCLK    = sclk_q;
    assign bus.MOSI    = mosi_q;
    assign bus.CS_N    = cs_n_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: time-since-acceptance model checked every cycle,
// plus directed transfers with literal expectations.
module tb_spi_master_ctrl;
    localparam int DW    = 8;
    localparam int C     = 4;
    localparam int END_T = (2 * DW + 1) * C;
`ifdef SPI_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    logic CLK = 1'b0;
    logic CLR = 1'b0;
    int   miso_mode = 0;   // 0: MISO=0, 1: MISO=1, 2: loopback from MOSI
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    bit   cmp_en = 1'b0;
    int   done_cnt = 0;
    int   sclk_rises = 0;
    logic prev_sclk = 1'b0;

    spi_master_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    assign bus.MISO = (miso_mode == 2) ? bus.MOSI : (miso_mode == 1);

    spi_master_ctrl #(.DATA_WIDTH(DW), .CLK_DIV(C)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus.master)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a transfer is just "t cycles since acceptance".
    bit         m_active = 1'b0;
    int         m_t = 0;
    logic [7:0] m_tx = 8'h00;
    logic [7:0] m_rx = 8'h00;
    int         m_mode = 0;
    bit         m_done = 1'b0;

    function automatic logic [7:0] rx_expect(input logic [7:0] tx, input int mode);
        if (mode == 2) return tx;
        if (mode == 1) return 8'hFF;
        return 8'h00;
    endfunction

    function automatic logic tx_bit(input logic [7:0] w, input int i);
        return LSB ? w[i] : w[DW-1-i];
    endfunction

    always @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            m_active = 1'b0;
            m_t      = 0;
            m_rx     = 8'h00;
            m_done   = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_active) begin
                m_t++;
                if (m_t == END_T) begin
                    m_active = 1'b0;
                    m_rx     = rx_expect(m_tx, m_mode);
                    m_done   = 1'b1;
                end
            end else if (bus.START) begin
                m_active = 1'b1;
                m_t      = 0;
                m_tx     = bus.TX_DATA;
                m_mode   = miso_mode;
            end
        end
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            int  idx;
            logic e_sclk, e_mosi;
            idx    = m_t / (2 * C);
            if (idx > DW - 1) idx = DW - 1;
            e_sclk = m_active && (((m_t / C) % 2) == 1);
            e_mosi = m_active ? tx_bit(m_tx, idx) : 1'b0;
            check("busy", bus.BUSY, m_active);
            check("cs_n", bus.CS_N, !m_active);
            check("sclk", bus.SCLK, e_sclk);
            check("mosi", bus.MOSI, e_mosi);
            check("done", bus.DONE, m_done);
            check("rx_data", bus.RX_DATA, m_rx);
            if (bus.DONE === 1'b1) done_cnt++;
            if (bus.SCLK === 1'b1 && prev_sclk === 1'b0) sclk_rises++;
            prev_sclk = bus.SCLK;
        end
    end

    task automatic start_xfer(input logic [7:0] tx, input int mode, output int acc);
        @(posedge CLK);
        #2;
        bus.TX_DATA = tx;
        miso_mode   = mode;
        bus.START   = 1'b1;
        @(posedge CLK);
        #2;
        acc       = cyc;
        bus.START = 1'b0;
    endtask

    task automatic wait_done(input string name, output int dcyc);
        bit seen = 1'b0;
        dcyc = -1;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge CLK);
            if (bus.DONE === 1'b1) begin
                seen = 1'b1;
                dcyc = cyc;
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: DONE not seen within 200 cycles", name);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, d1, d2, n0, r0;
        bus.START   = 1'b0;
        bus.TX_DATA = 8'h00;

        #1 CLR = 1'b1;
        #2;
        check("rst_rx", bus.RX_DATA, 8'h00);
        check("rst_busy", bus.BUSY, 1'b0);
        check("rst_done", bus.DONE, 1'b0);
        check("rst_sclk", bus.SCLK, 1'b0);
        check("rst_mosi", bus.MOSI, 1'b0);
        check("rst_cs_n", bus.CS_N, 1'b1);
        cmp_en = 1'b1;
        repeat (2) @(posedge CLK);
        #2 CLR = 1'b0;

        // loopback 0xA5
        #1;
        n0 = done_cnt;
        r0 = sclk_rises;
        start_xfer(8'hA5, 2, acc);
        wait_done("lb_a5", d1);
        check("lb_rx", bus.RX_DATA, 8'hA5);
        check("lb_done_edge", d1 - acc, 68);
        check("lb_busy_at_done", bus.BUSY, 1'b0);
        check("lb_cs_n_at_done", bus.CS_N, 1'b1);
        #1;
        check("lb_sclk_pulses", sclk_rises - r0, 8);
        check("lb_done_count", done_cnt - n0, 1);

        // MISO tied high, TX all zero
        start_xfer(8'h00, 1, acc);
        wait_done("miso1", d1);
        check("miso1_rx", bus.RX_DATA, 8'hFF);

        // CLR pulse at edge 20 of a transfer
        #1;
        n0 = done_cnt;
        start_xfer(8'hA5, 2, acc);
        repeat (20) @(posedge CLK);
        #2 CLR = 1'b1;
        #1;
        check("clr_cs_n", bus.CS_N, 1'b1);
        check("clr_sclk", bus.SCLK, 1'b0);
        check("clr_busy", bus.BUSY, 1'b0);
        check("clr_rx", bus.RX_DATA, 8'h00);
        #1 CLR = 1'b0;
        repeat (80) @(negedge CLK);
        #1;
        check("clr_no_done", done_cnt - n0, 0);
        start_xfer(8'h3C, 2, acc);
        wait_done("after_clr", d1);
        check("after_clr_rx", bus.RX_DATA, 8'h3C);
        check("after_clr_done_edge", d1 - acc, 68);

        // MISO tied low
        start_xfer(8'hFF, 0, acc);
        wait_done("miso0", d1);
        check("miso0_rx", bus.RX_DATA, 8'h00);

        // START and TX change while busy are ignored
        #1;
        n0 = done_cnt;
        start_xfer(8'hA5, 2, acc);
        repeat (29) @(posedge CLK);
        #2;
        bus.START   = 1'b1;
        bus.TX_DATA = 8'h3C;
        @(posedge CLK);
        #2 bus.START = 1'b0;
        wait_done("ign", d1);
        check("ign_rx", bus.RX_DATA, 8'hA5);
        repeat (10) @(negedge CLK);
        check("ign_idle_busy", bus.BUSY, 1'b0);
        #1;
        check("ign_done_count", done_cnt - n0, 1);

        // START held high across two transfers
        n0 = done_cnt;
        @(posedge CLK);
        #2;
        bus.TX_DATA = 8'h5A;
        miso_mode   = 2;
        bus.START   = 1'b1;
        wait_done("held1", d1);
        check("held1_rx", bus.RX_DATA, 8'h5A);
        bus.TX_DATA = 8'hC3;
        @(posedge CLK);
        #2;
        bus.START = 1'b0;
        @(negedge CLK);
        check("held_cs_low_after_done", bus.CS_N, 1'b0);
        wait_done("held2", d2);
        check("held2_rx", bus.RX_DATA, 8'hC3);
        check("held_done_gap", d2 - d1, 69);
        #1;
        check("held_done_count", done_cnt - n0, 2);

        // single set bit: exercises bit ordering
        start_xfer(8'h01, 2, acc);
        wait_done("one", d1);
        check("one_rx", bus.RX_DATA, 8'h01);

        repeat (5) @(negedge CLK);
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
